// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / data load-store) arbiter in front of a single SRAM, with alignment/range
// checking and a WAIT timeout. Define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default grants D.
module sram_arbiter #(
  parameter int MEM_BYTES = 4096,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] waitCount;
  logic          grantD;
  logic          pickD;
  logic          latch;
  logic          legal;
  logic [31:0]   selAddr;
  logic          portReady;
  logic          portErr;
  logic [31:0]   portRdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic lastGrantD;

  // On a tie, hand the grant to whichever port did not win last time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastGrantD <= 1'b1;
    end else if (latch) begin
      lastGrantD <= pickD;
    end
  end

  assign pickD = d_req && (!i_req || !lastGrantD);
`else
  assign pickD = d_req;
`endif

  assign selAddr = pickD ? d_addr : i_addr;
  assign legal   = (selAddr[1:0] == 2'b00) && (selAddr < MEM_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      waitCount <= '0;
      grantD    <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      state <= stateNext;
      m_req <= latch && legal;
      if (latch) begin
        grantD  <= pickD;
        m_addr  <= selAddr;
        m_we    <= pickD && d_we;
        m_wdata <= pickD ? d_wdata : 32'h0;
      end
      if (state == WAIT && stateNext == WAIT) begin
        waitCount <= waitCount + CW'(1);
      end else begin
        waitCount <= '0;
      end
    end
  end

  // A timeout reuses ERR so the abort pulse looks exactly like an illegal-address abort.
  always_comb begin
    stateNext = state;
    latch     = 1'b0;
    portReady = 1'b0;
    portErr   = 1'b0;
    portRdata = '0;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          latch     = 1'b1;
          stateNext = legal ? WAIT : ERR;
        end
      end
      WAIT: begin
        portReady = m_ready;
        portRdata = m_ready ? m_rdata : 32'h0;
        if (m_ready) begin
          stateNext = IDLE;
        end else if (waitCount == LAST_WAIT) begin
          stateNext = ERR;
        end
      end
      ERR: begin
        portReady = 1'b1;
        portErr   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    i_ready = portReady && !grantD;
    i_err   = portErr && !grantD;
    i_rdata = grantD ? 32'h0 : portRdata;
    d_ready = portReady && grantD;
    d_err   = portErr && grantD;
    d_rdata = grantD ? portRdata : 32'h0;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, size of the SRAM address window in bytes.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before an access is aborted.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (low = reset).
REQ-005 SHALL have ports i_req  input  1, i_addr  input  32, i_rdata  output  32, i_ready  output  1, i_err  output  1  for the instruction-fetch port (read-only).
REQ-006 SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  32, d_wdata  input  32, d_rdata  output  32, d_ready  output  1, d_err  output  1  for the data load/store port.
REQ-007 SHALL have ports m_req  output  1, m_we  output  1, m_addr  output  32, m_wdata  output  32, m_rdata  input  32, m_ready  input  1  for the SRAM peripheral.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, ERR; reset state IDLE.
REQ-009 Requester protocol SHALL be: hold req and fields stable until a one-cycle ready pulse; ready with err=0 means success, ready with err=1 means aborted.
REQ-010 In IDLE with any req, SHALL latch grant (I or D) and the granted port's addr/we/wdata into registers on the same edge.
REQ-011 Request SHALL be illegal if addr[1:0] != 0 or addr >= MEM_BYTES; illegal grant SHALL go to ERR with m_req kept 0.
REQ-012 Legal grant SHALL go to WAIT and drive registered m_req=1 for exactly the first WAIT cycle; m_req=0 otherwise.
REQ-013 m_addr/m_we/m_wdata SHALL equal the latched values throughout WAIT; for I grants m_we=0 and m_wdata=0.
REQ-014 In WAIT, granted port's ready SHALL equal m_ready and its rdata SHALL equal m_rdata (combinational pass-through), err=0; on m_ready the FSM SHALL return to IDLE.
REQ-015 Nominal latency SHALL be: req seen at edge N, m_req high cycle N+1, ready/rdata at cycle N+2 with a 1-cycle SRAM.
REQ-016 In WAIT, a cycle counter SHALL start at 0; if TIMEOUT cycles elapse without m_ready, granted port SHALL see ready=1, err=1 for one cycle and FSM SHALL return to IDLE; a late m_ready SHALL then be ignored.
REQ-017 ERR SHALL last exactly one cycle, assert ready=1 and err=1 on the granted port, then return to IDLE.
REQ-018 Non-granted port's ready and err SHALL be 0 at all times; rdata of a port SHALL be 0 whenever its ready is 0.
REQ-019 A requester holding req after its ready SHALL be treated as a new transaction in the following IDLE cycle (back-to-back legal, one IDLE cycle between accesses).
REQ-020 Changes to req or fields of the granted port during WAIT/ERR SHALL have no effect on the in-flight access.

Reset
REQ-021 While reset is low, SHALL force FSM=IDLE, counter=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, all ready/err/rdata=0, last-grant=D.
REQ-022 Reset asserted mid-WAIT SHALL abandon the access with no ready pulse to any port.
REQ-023 First rising edge after reset deasserts SHALL evaluate requests normally from IDLE.

Configuration
REQ-024 With macro SRAM_ARB_ROUND_ROBIN_EN defined, simultaneous i_req and d_req in IDLE SHALL grant the port not granted last (first tie after reset goes to I); last-grant updates on every grant.
REQ-025 Without SRAM_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always grant D; last-grant register SHALL not be implemented.

Verification
REQ-026 Single fetch: mem[0x10]=0xDEADBEEF, i_req=1 i_addr=0x40 -> m_req one cycle with m_addr=0x40 m_we=0, i_ready=1 i_rdata=0xDEADBEEF two cycles after req, i_err=0.
REQ-027 Store then load: d_we=1 d_addr=0x100 d_wdata=0x12345678 -> d_ready; then d_we=0 same addr -> d_rdata=0x12345678.
REQ-028 Contention, both req held 4 transactions: macro defined -> grant order I,D,I,D; macro undefined -> D,D,D,D with i_ready never asserted.
REQ-029 Illegal: d_addr=0x102 and d_addr=0x1000 (MEM_BYTES=4096) -> m_req stays 0, d_ready=1 d_err=1 one cycle after grant.
REQ-030 Timeout: m_ready tied 0, TIMEOUT=15, i_req at 0x0 -> i_ready=1 i_err=1 after 15 WAIT cycles, FSM back to IDLE; late m_ready ignored.
REQ-031 Reset mid-WAIT: pull reset low during WAIT -> all outputs 0 immediately, no ready pulse; after release a new d_req completes normally.
